// File: rtl/reg_file_param_if.sv
`default_nettype none
// ============================================================================
//  Module      : reg_file_param_if
//  Description : Register-file access bus. Write, two read ports,
//                condition-code load and clear-sweep control.
//  Revision    : 1.0 - initial release
// ============================================================================
interface reg_file_param_if #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 8
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic             LD_REG;
  logic [AW-1:0]    DR;
  logic [WIDTH-1:0] Data_In;
  logic [AW-1:0]    SR1;
  logic [AW-1:0]    SR2;
  logic [WIDTH-1:0] SR1_Out;
  logic [WIDTH-1:0] SR2_Out;
  logic             LD_CC;
  logic             N;
  logic             Z;
  logic             P;
  logic             Clear_Req;
  logic             Clear_Busy;

  modport master (
    output LD_REG, DR, Data_In, SR1, SR2, LD_CC, Clear_Req,
    input  SR1_Out, SR2_Out, N, Z, P, Clear_Busy
  );

  modport slave (
    input  LD_REG, DR, Data_In, SR1, SR2, LD_CC, Clear_Req,
    output SR1_Out, SR2_Out, N, Z, P, Clear_Busy
  );
endinterface
`default_nettype wire

// File: rtl/reg_file_param.sv
`default_nettype none
// ============================================================================
//  Module      : reg_file_param
//  Description : Parameterised 1W/2R register file with write bypass,
//                N/Z/P condition codes and a sequential clear sweep.
//  Revision    : 1.0 - initial release
// ============================================================================
module reg_file_param #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 8
) (
  input  wire logic        Clk,
  input  wire logic        Reset,
  reg_file_param_if.slave  bus
);
  localparam int           AW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0]  DEPTH_W  = (AW + 1)'(DEPTH);
  localparam logic [AW-1:0] LAST_IDX = AW'(DEPTH - 1);

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [AW-1:0]    idx_q, idx_d;
  logic [WIDTH-1:0] regs_q [DEPTH];
  logic [WIDTH-1:0] regs_d [DEPTH];
  logic             n_q, n_d;
  logic             z_q, z_d;
  logic             p_q, p_d;

  logic             wr_in_range;
  logic             bypass_en;
  logic [WIDTH-1:0] sr1_out;
  logic [WIDTH-1:0] sr2_out;

  // Addresses past DEPTH exist only for non-power-of-two depths.
  assign wr_in_range = ({1'b0, bus.DR} < DEPTH_W);
  assign bypass_en   = (state_q == ST_IDLE) && bus.LD_REG && wr_in_range;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    regs_d  = regs_q;
    n_d     = n_q;
    z_d     = z_q;
    p_d     = p_q;

    case (state_q)
      ST_IDLE: begin
        if (bus.LD_REG && wr_in_range) begin
          regs_d[bus.DR] = bus.Data_In;
        end
        if (bus.LD_CC) begin
          n_d = bus.Data_In[WIDTH-1];
          z_d = (bus.Data_In == '0);
          p_d = !bus.Data_In[WIDTH-1] && (bus.Data_In != '0);
        end
        if (bus.Clear_Req) begin
          state_d = ST_CLEAR;
          idx_d   = '0;
        end
      end
      ST_CLEAR: begin
        regs_d[idx_q] = '0;
        if (idx_q == LAST_IDX) begin
          state_d = ST_IDLE;
          idx_d   = '0;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        idx_d   = '0;
      end
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      n_q     <= 1'b0;
      z_q     <= 1'b1;
      p_q     <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        regs_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      n_q     <= n_d;
      z_q     <= z_d;
      p_q     <= p_d;
      regs_q  <= regs_d;
    end
  end

  always_comb begin
    sr1_out = '0;
    sr2_out = '0;
    if ({1'b0, bus.SR1} < DEPTH_W) sr1_out = regs_q[bus.SR1];
    if ({1'b0, bus.SR2} < DEPTH_W) sr2_out = regs_q[bus.SR2];
    if (bypass_en && (bus.DR == bus.SR1)) sr1_out = bus.Data_In;
    if (bypass_en && (bus.DR == bus.SR2)) sr2_out = bus.Data_In;
  end

  assign bus.SR1_Out    = sr1_out;
  assign bus.SR2_Out    = sr2_out;
  assign bus.N          = n_q;
  assign bus.Z          = z_q;
  assign bus.P          = p_q;
  assign bus.Clear_Busy = (state_q == ST_CLEAR);
endmodule
`default_nettype wire
